// File: rtl/pc_fetch_gen_if.sv
// pc_fetch_gen_if
// Groups the fetch-stage PC generator's control inputs and fetch outputs.
//   master : Execute / hazard unit / memory side; drives StallF, PCSrcE,
//            PCTargetE, TrapE, HaltE, Resume, IMemReady and observes outputs.
//   slave  : pc_fetch_gen; drives PCF, PCPlus4F, FetchValidF, MisalignF,
//            Halted, FetchCount.
interface pc_fetch_gen_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             StallF;
    logic             PCSrcE;
    logic [XLEN-1:0]  PCTargetE;
    logic             TrapE;
    logic             HaltE;
    logic             Resume;
    logic             IMemReady;
    logic [XLEN-1:0]  PCF;
    logic [XLEN-1:0]  PCPlus4F;
    logic             FetchValidF;
    logic             MisalignF;
    logic             Halted;
    logic [CNT_W-1:0] FetchCount;

    modport master (
        output StallF, PCSrcE, PCTargetE, TrapE, HaltE, Resume, IMemReady,
        input  PCF, PCPlus4F, FetchValidF, MisalignF, Halted, FetchCount
    );

    modport slave (
        input  StallF, PCSrcE, PCTargetE, TrapE, HaltE, Resume, IMemReady,
        output PCF, PCPlus4F, FetchValidF, MisalignF, Halted, FetchCount
    );
endinterface

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen
// Fetch-stage program-counter generator: reset/trap vectors, redirect from
// Execute with alignment check, memory-ready handshake, halt and fetch counter.
//   CLK : clock, all state updates on posedge
//   RST : asynchronous active-high reset
//   bus : pc_fetch_gen_if slave modport (controls in, PCF and status out)
//
// state | meaning
// BOOT  | one idle cycle after reset, PCF = RESET_VECTOR, no fetch
// RUN   | fetching, next PC chosen by trap/redirect/hold/increment
// HALT  | fetch frozen until Resume, all other controls ignored
module pc_fetch_gen #(
    parameter int              XLEN         = 32,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              CNT_W        = 32
) (
    input  logic CLK,
    input  logic RST,
    pc_fetch_gen_if.slave bus
);

    localparam int              OFF_W = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] INC   = XLEN'(INSTR_BYTES);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             misalign_q, misalign_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  pc_plus;
    logic             fetch_done;
    logic             target_misaligned;

    assign pc_plus           = pc_q + INC;
    // valid_q mirrors "state is RUN", so this is the completed-fetch condition.
    assign fetch_done        = valid_q & bus.IMemReady & ~bus.StallF;
    assign target_misaligned = |bus.PCTargetE[OFF_W-1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.TrapE) begin
                    pc_d = TRAP_VECTOR;
                end else if (bus.PCSrcE && target_misaligned) begin
                    pc_d       = TRAP_VECTOR;
                    misalign_d = 1'b1;
                end else if (bus.PCSrcE) begin
                    pc_d = bus.PCTargetE;
                end else if (bus.StallF || !bus.IMemReady) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_plus;
                end

                cnt_d = cnt_q + CNT_W'(fetch_done);

                if (bus.HaltE) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (bus.Resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Status outputs are registered copies of the next state.
        valid_d  = (state_d == RUN);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.PCF         = pc_q;
    assign bus.PCPlus4F    = pc_plus;
    assign bus.FetchValidF = valid_q;
    assign bus.MisalignF   = misalign_q;
    assign bus.Halted      = halted_q;
    assign bus.FetchCount  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
module tb_pc_fetch_gen;

    logic CLK;
    logic RST;
    int   tests_run;
    int   tests_failed;

    pc_fetch_gen_if #(.XLEN(32), .CNT_W(32)) bus ();

    pc_fetch_gen #(
        .XLEN        (32),
        .INSTR_BYTES (4),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100),
        .CNT_W       (32)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.StallF    = 1'b0;
        bus.PCSrcE    = 1'b0;
        bus.PCTargetE = 32'h0;
        bus.TrapE     = 1'b0;
        bus.HaltE     = 1'b0;
        bus.Resume    = 1'b0;
        bus.IMemReady = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [4];
        logic        exp_fv [4];
        exp_pc = '{32'h0, 32'h0, 32'h4, 32'h8};
        exp_fv = '{1'b0, 1'b1, 1'b1, 1'b1};
        clear_inputs();
        RST = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.Halted !== 1'b0 || bus.MisalignF !== 1'b0 || bus.FetchCount !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_status: halted=%b misalign=%b count=%0d, want 0 0 0",
                     bus.Halted, bus.MisalignF, bus.FetchCount);
        end
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            tests_run++;
            if (bus.PCF !== exp_pc[i] || bus.FetchValidF !== exp_fv[i]) begin
                tests_failed++;
                $display("FAIL boot_seq[%0d]: pc=%h fv=%b, want pc=%h fv=%b",
                         i, bus.PCF, bus.FetchValidF, exp_pc[i], exp_fv[i]);
            end
        end
        tests_run++;
        if (bus.FetchCount !== 32'd2) begin
            tests_failed++;
            $display("FAIL boot_count: got %0d want 2", bus.FetchCount);
        end
    endtask

    task automatic test_stall_wait();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h8, 32'h8, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            bus.StallF    = (i < 2);
            bus.IMemReady = (i != 2);
            step();
            tests_run++;
            if (bus.PCF !== exp_pc[i] || bus.FetchValidF !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_pc[%0d]: pc=%h fv=%b, want pc=%h fv=1",
                         i, bus.PCF, bus.FetchValidF, exp_pc[i]);
            end
        end
        clear_inputs();
        tests_run++;
        if (bus.FetchCount !== 32'd3) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d want 3", bus.FetchCount);
        end
        tests_run++;
        if (bus.PCPlus4F !== 32'h10) begin
            tests_failed++;
            $display("FAIL pcplus4: got %h want 00000010", bus.PCPlus4F);
        end
    endtask

    task automatic test_redirect_priority();
        bus.PCSrcE    = 1'b1;
        bus.PCTargetE = 32'h40;
        bus.StallF    = 1'b1;
        bus.IMemReady = 1'b0;
        step();
        tests_run++;
        if (bus.PCF !== 32'h40 || bus.MisalignF !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_stalled: pc=%h misalign=%b, want 00000040 0",
                     bus.PCF, bus.MisalignF);
        end
        bus.TrapE = 1'b1;
        step();
        tests_run++;
        if (bus.PCF !== 32'h100 || bus.MisalignF !== 1'b0) begin
            tests_failed++;
            $display("FAIL trap_over_redirect: pc=%h misalign=%b, want 00000100 0",
                     bus.PCF, bus.MisalignF);
        end
        tests_run++;
        if (bus.FetchCount !== 32'd3) begin
            tests_failed++;
            $display("FAIL redirect_count: got %0d want 3", bus.FetchCount);
        end
        clear_inputs();
    endtask

    task automatic test_misalign();
        bus.PCSrcE    = 1'b1;
        bus.PCTargetE = 32'h42;
        bus.StallF    = 1'b1;
        step();
        tests_run++;
        if (bus.PCF !== 32'h100 || bus.MisalignF !== 1'b1 || bus.FetchCount !== 32'd3) begin
            tests_failed++;
            $display("FAIL misalign_hit: pc=%h misalign=%b count=%0d, want 00000100 1 3",
                     bus.PCF, bus.MisalignF, bus.FetchCount);
        end
        clear_inputs();
        step();
        tests_run++;
        if (bus.PCF !== 32'h104 || bus.MisalignF !== 1'b0 || bus.FetchCount !== 32'd4) begin
            tests_failed++;
            $display("FAIL misalign_after: pc=%h misalign=%b count=%0d, want 00000104 0 4",
                     bus.PCF, bus.MisalignF, bus.FetchCount);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt [2];
        tgt = '{32'h20, 32'h30};
        for (int i = 0; i < 2; i++) begin
            bus.PCSrcE    = 1'b1;
            bus.PCTargetE = tgt[i];
            bus.StallF    = 1'b1;
            step();
            tests_run++;
            if (bus.PCF !== tgt[i]) begin
                tests_failed++;
                $display("FAIL b2b_redirect[%0d]: got %h want %h", i, bus.PCF, tgt[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_halt_resume();
        bus.HaltE     = 1'b1;
        bus.PCSrcE    = 1'b1;
        bus.PCTargetE = 32'h80;
        step();
        tests_run++;
        if (bus.PCF !== 32'h80 || bus.Halted !== 1'b1 || bus.FetchValidF !== 1'b0 ||
            bus.FetchCount !== 32'd5) begin
            tests_failed++;
            $display("FAIL halt_enter: pc=%h halted=%b fv=%b count=%0d, want 00000080 1 0 5",
                     bus.PCF, bus.Halted, bus.FetchValidF, bus.FetchCount);
        end
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            bus.PCSrcE    = i[0];
            bus.TrapE     = ~i[0];
            bus.PCTargetE = 32'h200;
            bus.HaltE     = 1'b1;
            step();
            tests_run++;
            if (bus.PCF !== 32'h80 || bus.Halted !== 1'b1 || bus.FetchCount !== 32'd5) begin
                tests_failed++;
                $display("FAIL halt_frozen[%0d]: pc=%h halted=%b count=%0d, want 00000080 1 5",
                         i, bus.PCF, bus.Halted, bus.FetchCount);
            end
        end
        clear_inputs();
        bus.Resume = 1'b1;
        step();
        tests_run++;
        if (bus.PCF !== 32'h80 || bus.Halted !== 1'b0 || bus.FetchValidF !== 1'b1) begin
            tests_failed++;
            $display("FAIL resume: pc=%h halted=%b fv=%b, want 00000080 0 1",
                     bus.PCF, bus.Halted, bus.FetchValidF);
        end
        bus.Resume = 1'b0;
        step();
        tests_run++;
        if (bus.PCF !== 32'h84 || bus.FetchCount !== 32'd6) begin
            tests_failed++;
            $display("FAIL resume_next: pc=%h count=%0d, want 00000084 6", bus.PCF, bus.FetchCount);
        end
    endtask

    task automatic test_wrap_async_reset();
        bus.PCSrcE    = 1'b1;
        bus.PCTargetE = 32'hFFFF_FFFC;
        step();
        tests_run++;
        if (bus.PCF !== 32'hFFFF_FFFC || bus.PCPlus4F !== 32'h0 || bus.FetchCount !== 32'd7) begin
            tests_failed++;
            $display("FAIL wrap_target: pc=%h plus4=%h count=%0d, want fffffffc 00000000 7",
                     bus.PCF, bus.PCPlus4F, bus.FetchCount);
        end
        clear_inputs();
        step();
        tests_run++;
        if (bus.PCF !== 32'h0 || bus.FetchCount !== 32'd8) begin
            tests_failed++;
            $display("FAIL wrap_pc: pc=%h count=%0d, want 00000000 8", bus.PCF, bus.FetchCount);
        end
        bus.HaltE = 1'b1;
        step();
        bus.HaltE = 1'b0;
        tests_run++;
        if (bus.PCF !== 32'h4 || bus.Halted !== 1'b1 || bus.FetchCount !== 32'd9) begin
            tests_failed++;
            $display("FAIL pre_reset_halt: pc=%h halted=%b count=%0d, want 00000004 1 9",
                     bus.PCF, bus.Halted, bus.FetchCount);
        end
        #2;
        RST = 1'b1;
        #1;
        tests_run++;
        if (bus.PCF !== 32'h0 || bus.FetchCount !== 32'd0 || bus.Halted !== 1'b0 ||
            bus.FetchValidF !== 1'b0 || bus.MisalignF !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: pc=%h count=%0d halted=%b fv=%b misalign=%b, want 0 0 0 0 0",
                     bus.PCF, bus.FetchCount, bus.Halted, bus.FetchValidF, bus.MisalignF);
        end
        step();
        RST = 1'b0;
        step();
        tests_run++;
        if (bus.PCF !== 32'h0 || bus.FetchValidF !== 1'b1 || bus.FetchCount !== 32'd0) begin
            tests_failed++;
            $display("FAIL post_reset_run: pc=%h fv=%b count=%0d, want 00000000 1 0",
                     bus.PCF, bus.FetchValidF, bus.FetchCount);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST          = 1'b1;
        clear_inputs();
        test_reset();
        test_stall_wait();
        test_redirect_priority();
        test_misalign();
        test_back_to_back();
        test_halt_resume();
        test_wrap_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised fetch-stage program-counter generator for the pipelined core. It replaces the bare stall-only PC register and adds:
- reset vector and trap vector;
- branch/jump redirect from Execute, with a misalignment check;
- instruction-memory ready handshake;
- halt state;
- fetch counter.

It sits between the next-PC logic inputs from Execute and the instruction-memory address port, and drives PCF and PCPlus4F to the IF/ID register.

## Interface
Parameters:
- XLEN, 32, PC width in bits.
- INSTR_BYTES, 4, PC increment; power of two, at least 2.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, target on trap or misaligned redirect.
- CNT_W, 32, width of the fetch counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- StallF  in  1  hazard-unit stall; hold PC.
- PCSrcE  in  1  redirect request from Execute.
- PCTargetE  in  XLEN  redirect target.
- TrapE  in  1  trap request; overrides redirect.
- HaltE  in  1  enter HALT after the current cycle.
- Resume  in  1  leave HALT.
- IMemReady  in  1  instruction memory accepts/returns this cycle.
- PCF  out  XLEN  current fetch address.
- PCPlus4F  out  XLEN  PCF + INSTR_BYTES, modulo 2^XLEN.
- FetchValidF  out  1  PCF is a live fetch this cycle.
- MisalignF  out  1  one-cycle pulse: rejected misaligned redirect.
- Halted  out  1  FSM is in HALT.
- FetchCount  out  CNT_W  number of completed fetches.

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset (asynchronous):
  - state = BOOT, PCF = RESET_VECTOR.
  - FetchValidF = 0, MisalignF = 0, Halted = 0, FetchCount = 0.
- BOOT: lasts exactly one cycle after RST deasserts, then RUN. PCF is unchanged and FetchValidF = 0.
- RUN: FetchValidF = 1.
- A fetch completes on a cycle with FetchValidF & IMemReady & !StallF.
- Next-PC priority in RUN, highest first:
  1. TrapE → TRAP_VECTOR.
  2. PCSrcE with a misaligned target → TRAP_VECTOR, and MisalignF = 1 next cycle.
  3. PCSrcE with an aligned target → PCTargetE.
  4. StallF or !IMemReady → hold PCF.
  5. Otherwise → PCPlus4F.
- "Misaligned" means PCTargetE[log2(INSTR_BYTES)-1:0] != 0.
- Trap and redirect are taken even when StallF or !IMemReady; the pipeline flush is the hazard unit's job.
- HaltE in RUN:
  - The next-PC update for that cycle still applies.
  - State = HALT from the next cycle; a simultaneous TrapE/PCSrcE target is retained in PCF.
- HALT:
  - FetchValidF = 0, Halted = 1, PCF frozen.
  - TrapE, PCSrcE, StallF, HaltE and IMemReady are ignored.
  - Resume → RUN next cycle, fetching the frozen PCF.
- FetchCount increments by 1 per completed fetch and wraps modulo 2^CNT_W. Redirects do not count; only completed fetches do.
- PCPlus4F is combinational from PCF; the increment wraps modulo 2^XLEN.
- All other outputs are registered.

## Timing
- RST asserted mid-operation: every output returns to its reset value asynchronously, including during HALT or a pending redirect.
- First live fetch: cycle 2 after RST deasserts. Cycle 1 is BOOT.
- Redirect latency: PCTargetE is sampled at posedge N and appears on PCF after posedge N, usable by the fetch in cycle N+1. No bubble is inserted by this block.
- MisalignF: asserted for exactly one cycle, the cycle in which PCF = TRAP_VECTOR first appears.
- Back-to-back redirects in consecutive cycles: each is applied; the last one wins.
- Stall held across multiple cycles: PCF is stable and FetchCount is unchanged.
- IMemReady low for k cycles: PCF is held for k cycles with FetchValidF = 1. The counter increments only on the ready cycle.
- Wrap-around: PCF = 2^XLEN − INSTR_BYTES with a completed fetch → PCF = 0.

## Test plan
- Reset/boot: RST pulse, then 3 free-running cycles with IMemReady = 1.
  - PCF sequence 0x0, 0x0, 0x4, 0x8.
  - FetchValidF sequence 0, 1, 1, 1.
  - FetchCount ends at 2.
- Stall and wait: StallF for 2 cycles at PCF = 0x8, then IMemReady = 0 for 1 cycle.
  - PCF holds 0x8 for 3 cycles, then 0xC.
  - FetchCount rises by only 1 across that window.
- Redirect priority: PCSrcE = 1, PCTargetE = 0x40, StallF = 1, IMemReady = 0 → PCF = 0x40 next cycle.
  - Same with TrapE = 1 → PCF = 0x100.
- Misaligned redirect: PCTargetE = 0x42.
  - PCF = 0x100 next cycle, MisalignF = 1 for exactly one cycle.
  - FetchCount is not incremented by the redirect.
- Halt/resume:
  - HaltE together with PCSrcE → 0x80: PCF = 0x80, Halted = 1, FetchValidF = 0.
  - PCF stays frozen for 5 cycles despite PCSrcE/TrapE toggling.
  - Resume → fetch at 0x80, then 0x84.
- Wrap and asynchronous reset:
  - Redirect to 0xFFFF_FFFC, then one completed fetch → PCF = 0x0.
  - Assert RST mid-cycle → PCF = 0x0, FetchCount = 0 immediately, with no clock edge.
